// File: rtl/fb_stream_writer.sv
// fb_stream_writer
// Producer side of the panel frame buffer: waits for a sync byte, then unpacks
// byte triplets {p0[11:4]} {p0[3:0],p1[11:8]} {p1[7:0]} into 12-bit pixels and
// writes them sequentially through RAM port A, addresses 0..NPIX-1.
// Optional build macro FB_WRITER_TIMEOUT_EN: aborts a frame (o_err pulse) when
// no byte arrives for TIMEOUT_CYCLES cycles while inside a frame. Without it
// o_err is tied low and the writer waits indefinitely for the next byte.
module fb_stream_writer #(
  parameter int          NPIX           = 4096,
  parameter int          ADDR_W         = 12,
  parameter int          BPP            = 12,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [BPP-1:0]    o_wdata,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err
);

  // Reject parameter sets the pixel packing and addressing cannot handle.
  if (BPP != 12 || (NPIX % 2) != 0 || NPIX < 2 || NPIX > (1 << ADDR_W) ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fb_stream_writer: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] NPIX_L = NPIX[ADDR_W:0];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   pix_q, pix_d;
  logic [7:0]        hi_q, hi_d;
  logic [3:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BPP-1:0]    wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hs;
  logic              in_frame;
  logic              tmo_hit;
  logic [ADDR_W:0]   pix_inc;

  // Ready is withheld in DONE and while the done pulse is visible, so the next
  // sync can only be taken after o_frame_done has been seen.
  assign o_ready  = (state_q != DONE) && !done_q;
  assign hs       = i_valid && o_ready;
  assign in_frame = (state_q == B0) || (state_q == B1) || (state_q == B2);
  assign pix_inc  = pix_q + 1'b1;

`ifdef FB_WRITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = in_frame && !hs && (tmo_q == TMO_LAST);

  // Idle-cycle counter: runs only while stalled inside a frame.
  always_comb begin
    tmo_d = '0;
    if (in_frame && !hs && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, pixel unpacking and write-port command generation.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hs && (i_data == SYNC_BYTE)) begin
          pix_d   = '0;
          busy_d  = 1'b1;
          state_d = B0;
        end
      end
      B0: begin
        if (hs) begin
          hi_d    = i_data;
          state_d = B1;
        end
      end
      B1: begin
        if (hs) begin
          addr_d  = pix_q[ADDR_W-1:0];
          wdata_d = {hi_q, i_data[7:4]};
          wr_en_d = 1'b1;
          lo_d    = i_data[3:0];
          pix_d   = pix_inc;
          state_d = B2;
        end
      end
      B2: begin
        if (hs) begin
          addr_d  = pix_q[ADDR_W-1:0];
          wdata_d = {lo_q, i_data};
          wr_en_d = 1'b1;
          pix_d   = pix_inc;
          state_d = (pix_inc == NPIX_L) ? DONE : B0;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort a stalled frame; already written pixels stay in RAM.
    if (tmo_hit) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  // Datapath, write-port and status registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pix_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_addr       = addr_q;
  assign o_wdata      = wdata_q;
  assign o_wr_en      = wr_en_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_fb_stream_writer.sv
// Bench for fb_stream_writer with a 4-pixel frame and a 16-cycle timeout.
module tb_fb_stream_writer;

  localparam int NPIX   = 4;
  localparam int ADDR_W = 12;
  localparam int TMO    = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [11:0]       d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        i_data;
  logic              i_valid;
  logic              o_ready;
  logic [ADDR_W-1:0] o_addr;
  logic [11:0]       o_wdata;
  logic              o_wr_en;
  logic              o_busy;
  logic              o_frame_done;
  logic              o_err;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;
  int  wr_cnt      = 0;
  int  done_cnt    = 0;
  int  err_cnt     = 0;

  always #5 clk = ~clk;

  fb_stream_writer #(
    .NPIX(NPIX), .ADDR_W(ADDR_W), .BPP(12), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_addr(o_addr), .o_wdata(o_wdata), .o_wr_en(o_wr_en),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  // Scoreboard: every write strobe is popped against the expected queue.
  always @(negedge clk) begin
    if (o_wr_en) begin
      wr_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got addr=%0h data=%03h, required no write", o_addr, o_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_addr !== mon_e.a || o_wdata !== mon_e.d) begin
          miscompares++;
          $display("FAIL wr_data: got (%0h,%03h), required (%0h,%03h)", o_addr, o_wdata, mon_e.a, mon_e.d);
        end
      end
    end
    if (o_frame_done) done_cnt++;
    if (o_err) err_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
    $fatal(1);
  end

  task automatic push(input int a, input int d);
    wr_t e;
    e.a = a[ADDR_W-1:0];
    e.d = d[11:0];
    exp_q.push_back(e);
  endtask

  // One byte per call; back-to-back calls keep i_valid high continuously.
  task automatic send_byte(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (2) @(posedge clk);
    #4;
    vectors += 7;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b, required 1", o_ready); end
    if (o_addr !== '0) begin miscompares++; $display("FAIL rst_addr: got %0h, required 0", o_addr); end
    if (o_wdata !== '0) begin miscompares++; $display("FAIL rst_wdata: got %0h, required 0", o_wdata); end
    if (o_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %b, required 0", o_wr_en); end
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    if (o_frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b, required 0", o_frame_done); end
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b, required 0", o_err); end
    rst_n = 1'b1;
    idle(2);
  endtask

  // Full frame at one byte per cycle with exact done/ready/busy timing.
  task automatic test_frame;
    int d0 = done_cnt;
    int w0 = wr_cnt;
    logic [7:0] b [6] = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    push(0, 12'h123); push(1, 12'h456); push(2, 12'hABC); push(3, 12'hDEF);
    send_byte(8'hA5);
    #3;
    vectors++;
    if (o_busy !== 1'b1) begin miscompares++; $display("FAIL frame_busy_rise: got %b, required 1", o_busy); end
    for (int i = 0; i < 6; i++) send_byte(b[i]);
    #3;
    vectors += 2;
    if (o_wr_en !== 1'b1) begin miscompares++; $display("FAIL frame_last_strobe: got %b, required 1", o_wr_en); end
    if (o_frame_done !== 1'b0) begin miscompares++; $display("FAIL frame_done_early: got %b, required 0", o_frame_done); end
    @(posedge clk);
    #4;
    vectors += 4;
    if (o_frame_done !== 1'b1) begin miscompares++; $display("FAIL frame_done_pulse: got %b, required 1", o_frame_done); end
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL frame_busy_fall: got %b, required 0", o_busy); end
    if (o_ready !== 1'b0) begin miscompares++; $display("FAIL frame_ready_low: got %b, required 0", o_ready); end
    if (o_wr_en !== 1'b0) begin miscompares++; $display("FAIL frame_wr_after: got %b, required 0", o_wr_en); end
    @(posedge clk);
    #4;
    vectors += 5;
    if (o_frame_done !== 1'b0) begin miscompares++; $display("FAIL frame_done_width: got %b, required 0", o_frame_done); end
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL frame_ready_back: got %b, required 1", o_ready); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL frame_pending: got %0d left, required 0", exp_q.size()); end
    if (wr_cnt != w0 + NPIX) begin miscompares++; $display("FAIL frame_wr_cnt: got %0d, required %0d", wr_cnt - w0, NPIX); end
    if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL frame_done_cnt: got %0d, required 1", done_cnt - d0); end
  endtask

  // Non-sync garbage is dropped; sync bytes inside a frame are pixel data.
  task automatic test_garbage_sync_data;
    int d0 = done_cnt;
    int w0 = wr_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle(2);
    #3;
    vectors += 2;
    if (wr_cnt != w0) begin miscompares++; $display("FAIL garbage_writes: got %0d, required 0", wr_cnt - w0); end
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL garbage_busy: got %b, required 0", o_busy); end
    push(0, 12'hA5A); push(1, 12'h5A5); push(2, 12'hA5A); push(3, 12'h5A5);
    repeat (7) send_byte(8'hA5);
    idle(3);
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL syncdata_pending: got %0d left, required 0", exp_q.size()); end
    if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL syncdata_done: got %0d, required 1", done_cnt - d0); end
  endtask

  // Bubble after every byte: each write strobes exactly one cycle after its byte.
  task automatic test_valid_toggle;
    int d0 = done_cnt;
    logic [7:0] b [6] = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    push(0, 12'h123); push(1, 12'h456); push(2, 12'hABC); push(3, 12'hDEF);
    send_byte(8'hA5);
    idle(1);
    for (int i = 0; i < 6; i++) begin
      send_byte(b[i]);
      #3;
      vectors++;
      if (o_wr_en !== (i % 3 != 0)) begin
        miscompares++;
        $display("FAIL toggle_strobe[%0d]: got %b, required %b", i, o_wr_en, (i % 3 != 0));
      end
      @(posedge clk);
      #3;
      vectors++;
      if (o_wr_en !== 1'b0) begin miscompares++; $display("FAIL toggle_gap[%0d]: got %b, required 0", i, o_wr_en); end
    end
    idle(3);
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL toggle_pending: got %0d left, required 0", exp_q.size()); end
    if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL toggle_done: got %0d, required 1", done_cnt - d0); end
  endtask

  // Asynchronous reset mid-frame, then a fresh frame starting at address 0.
  task automatic test_async_reset;
    int d0 = done_cnt;
    logic [7:0] b [6] = '{8'h11, 8'h12, 8'h22, 8'h33, 8'h34, 8'h44};
    push(0, 12'h123); push(1, 12'h456);
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    #3;
    vectors++;
    if (o_wr_en !== 1'b1) begin miscompares++; $display("FAIL arst_second_write: got %b, required 1", o_wr_en); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 5;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b, required 0", o_busy); end
    if (o_addr !== '0) begin miscompares++; $display("FAIL arst_addr: got %0h, required 0", o_addr); end
    if (o_wdata !== '0) begin miscompares++; $display("FAIL arst_wdata: got %0h, required 0", o_wdata); end
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready: got %b, required 1", o_ready); end
    if (o_wr_en !== 1'b0) begin miscompares++; $display("FAIL arst_wr_en: got %b, required 0", o_wr_en); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(3);
    vectors += 2;
    if (done_cnt != d0) begin miscompares++; $display("FAIL arst_no_done: got %0d, required 0", done_cnt - d0); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL arst_pending: got %0d left, required 0", exp_q.size()); end
    push(0, 12'h111); push(1, 12'h222); push(2, 12'h333); push(3, 12'h444);
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(b[i]);
    idle(3);
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL arst_refill_pending: got %0d left, required 0", exp_q.size()); end
    if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL arst_refill_done: got %0d, required 1", done_cnt - d0); end
  endtask

`ifdef FB_WRITER_TIMEOUT_EN
  // Stall inside a frame until the abort pulse, then confirm recovery.
  task automatic test_timeout;
    int  d0 = done_cnt;
    int  w0 = wr_cnt;
    int  k;
    bit  seen = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h12);
    for (k = 1; k <= TMO + 8; k++) begin
      @(posedge clk);
      #3;
      if (o_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors += 2;
    if (!seen) begin miscompares++; $display("FAIL tmo_err_missing: got no o_err in %0d cycles, required pulse", TMO + 8); end
    if (seen && k != TMO) begin miscompares++; $display("FAIL tmo_err_cycle: got %0d, required %0d", k, TMO); end
    vectors += 2;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL tmo_busy: got %b, required 0", o_busy); end
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL tmo_ready: got %b, required 1", o_ready); end
    @(posedge clk);
    #3;
    vectors += 3;
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL tmo_err_width: got %b, required 0", o_err); end
    if (wr_cnt != w0) begin miscompares++; $display("FAIL tmo_writes: got %0d, required 0", wr_cnt - w0); end
    if (done_cnt != d0) begin miscompares++; $display("FAIL tmo_done: got %0d, required 0", done_cnt - d0); end
    test_frame();
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_frame();
    test_garbage_sync_data();
    test_valid_toggle();
    test_async_reset();
`ifdef FB_WRITER_TIMEOUT_EN
    test_timeout();
`endif
    idle(2);
    vectors++;
    if (err_cnt != 0 && !`ifdef FB_WRITER_TIMEOUT_EN 1'b1 `else 1'b0 `endif) begin
      miscompares++;
      $display("FAIL err_spurious: got %0d pulses, required 0", err_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
